uart_rx_cfg: RTL

- Parametrised UART receiver; next generation of the fixed 8N1 receiver used in the UART test designs.
- 16x oversampling with 6-sample majority voting per bit.
- Adds configurable data width, runtime parity mode, 1 or 2 stop bits, runtime 16-bit baud divisor and a valid/ready output holding register.
- Reports parity, framing and overrun errors; sits between the synchronised RS-232 pin and the packet/command parser.

---
 rtl/uart_rx_cfg.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/uart_rx_cfg.sv
// UART receiver: 16x oversampling, 6-sample majority vote per bit, runtime parity and
// baud divisor, DATA_BITS/STOP_BITS build options, valid/ready holding register with overrun.
module uart_rx_cfg #(
  parameter int DATA_BITS   = 8,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic [15:0]          baud_div,
  input  logic [1:0]           parity_mode,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   rx_d;
  logic [15:0]            div_cnt, lat_div;
  logic [1:0]             lat_par;
  logic [3:0]             sub, bit_cnt;
  logic [2:0]             votes;
  logic                   stop_cnt;
  logic [DATA_BITS-1:0]   shreg;
  logic                   par_bad, frm_bad;
  logic                   done, pend_pe, pend_fe;

  logic rx_s, start_edge, tick, sample, decide, bit_val, par_on;
  assign rx_s       = sync[SYNC_STAGES-1];
  assign start_edge = rx_d & ~rx_s;
  assign tick       = (state != IDLE) && (div_cnt == lat_div);
  assign sample     = tick && (sub >= 4'd6) && (sub <= 4'd11);
  assign decide     = tick && (sub == 4'd12);
  assign bit_val    = (votes >= 3'd4);
  assign par_on     = lat_par[0] ^ lat_par[1];

  // Synchroniser idles high so reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= '1;
      rx_d <= 1'b1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], rx};
      rx_d <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      div_cnt  <= '0;
      lat_div  <= '0;
      lat_par  <= '0;
      sub      <= '0;
      bit_cnt  <= '0;
      votes    <= '0;
      stop_cnt <= 1'b0;
      shreg    <= '0;
      par_bad  <= 1'b0;
      frm_bad  <= 1'b0;
      done     <= 1'b0;
      pend_pe  <= 1'b0;
      pend_fe  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start_edge) begin
          state    <= START;
          busy     <= 1'b1;
          div_cnt  <= '0;
          sub      <= '0;
          votes    <= '0;
          bit_cnt  <= '0;
          stop_cnt <= 1'b0;
          par_bad  <= 1'b0;
          frm_bad  <= 1'b0;
          lat_div  <= baud_div;
          lat_par  <= parity_mode;
        end
      end else if (tick) begin
        div_cnt <= '0;
        sub     <= sub + 4'd1;
        if (sample) votes <= votes + {2'b00, rx_s};
        if (decide) begin
          votes <= '0;
          unique case (state)
            START: begin
              if (bit_val) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                state <= DATA;
              end
            end
            DATA: begin
              shreg   <= {bit_val, shreg[DATA_BITS-1:1]};
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == LAST_BIT) state <= par_on ? PARITY : STOP;
            end
            PARITY: begin
              par_bad <= ((^shreg) ^ bit_val) != (lat_par == 2'b10);
              state   <= STOP;
            end
            STOP: begin
              if (stop_cnt == LAST_STOP) begin
                // Frame ends at mid-stop so a back-to-back start edge is not missed.
                state   <= IDLE;
                busy    <= 1'b0;
                done    <= 1'b1;
                pend_pe <= par_bad;
                pend_fe <= frm_bad | ~bit_val;
              end else begin
                frm_bad  <= frm_bad | ~bit_val;
                stop_cnt <= stop_cnt + 1'b1;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end else begin
        div_cnt <= div_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out   <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (done && (!valid || ready)) begin
        data_out   <= shreg;
        parity_err <= pend_pe;
        frame_err  <= pend_fe;
        valid      <= 1'b1;
      end else begin
        if (done) overrun <= 1'b1;
        if (valid && ready) valid <= 1'b0;
      end
    end
  end

endmodule
